// File: rtl/flash_read_ctrl.sv
// Key-triggered SPI flash reader: one READ (0x03) of READ_LEN bytes from READ_ADDR per
// accepted key_flag, each byte presented on po_data with a one-cycle po_flag strobe.
module flash_read_ctrl #(
    parameter logic [23:0] READ_ADDR = 24'h00_0000,
    parameter logic [15:0] READ_LEN  = 16'd4,
    parameter logic [7:0]  SCK_DIV   = 8'd4
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_flag,
    input  logic       miso,
    output logic       cs_n,
    output logic       sck,
    output logic       mosi,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, SETUP, CMD, ADDR, DATA, HOLD} state_t;

    localparam logic [31:0] TX_WORD    = {8'h03, READ_ADDR};
    localparam logic [7:0]  PH_LAST    = SCK_DIV - 8'd1;
    localparam logic [7:0]  PH_RISE_M1 = (SCK_DIV >> 1) - 8'd1;
    localparam logic [15:0] LAST_BYTE  = READ_LEN - 16'd1;

    state_t      state;
    logic [7:0]  phase;
    logic [4:0]  bit_cnt;
    logic [15:0] byte_cnt;
    logic [31:0] tx_sr;
    logic [7:0]  shift_p0;
    logic        vld_p0;
    logic        in_bits;
    logic        bit_end;
    logic        rise_edge;

    assign in_bits   = (state == CMD) || (state == ADDR) || (state == DATA);
    assign bit_end   = (phase == PH_LAST);
    assign rise_edge = in_bits && (phase == PH_RISE_M1);

    // Stage p0: miso captured on the edge that raises sck
    always_ff @(posedge sys_clk) begin
        if (rise_edge && (state == DATA)) begin
            shift_p0 <= {shift_p0[6:0], miso};
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            phase    <= 8'd0;
            bit_cnt  <= 5'd0;
            byte_cnt <= 16'd0;
            tx_sr    <= 32'd0;
            vld_p0   <= 1'b0;
            cs_n     <= 1'b1;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            po_data  <= 8'h00;
            po_flag  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            // Output stage: a completed byte is published one cycle after its last sample
            vld_p0  <= 1'b0;
            po_flag <= vld_p0;
            if (vld_p0) begin
                po_data <= shift_p0;
            end

            case (state)
                IDLE: begin
                    phase    <= 8'd0;
                    bit_cnt  <= 5'd0;
                    byte_cnt <= 16'd0;
                    if (key_flag) begin
                        state <= SETUP;
                        cs_n  <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                SETUP: begin
                    phase <= bit_end ? 8'd0 : phase + 8'd1;
                    if (bit_end) begin
                        state <= CMD;
                        mosi  <= TX_WORD[31];
                        tx_sr <= {TX_WORD[30:0], 1'b0};
                    end
                end
                CMD, ADDR, DATA: begin
                    phase <= bit_end ? 8'd0 : phase + 8'd1;
                    if (rise_edge) begin
                        sck <= 1'b1;
                        if ((state == DATA) && (bit_cnt[2:0] == 3'd7)) begin
                            vld_p0 <= 1'b1;
                        end
                    end
                    if (bit_end) begin
                        // Zeros shift in behind the address, so mosi stays low through DATA
                        sck     <= 1'b0;
                        mosi    <= tx_sr[31];
                        tx_sr   <= {tx_sr[30:0], 1'b0};
                        bit_cnt <= bit_cnt + 5'd1;
                        if ((state == CMD) && (bit_cnt == 5'd7)) begin
                            state   <= ADDR;
                            bit_cnt <= 5'd0;
                        end
                        if ((state == ADDR) && (bit_cnt == 5'd23)) begin
                            state   <= DATA;
                            bit_cnt <= 5'd0;
                        end
                        if ((state == DATA) && (bit_cnt == 5'd7)) begin
                            bit_cnt <= 5'd0;
                            if (byte_cnt == LAST_BYTE) begin
                                state <= HOLD;
                            end else begin
                                byte_cnt <= byte_cnt + 16'd1;
                            end
                        end
                    end
                end
                HOLD: begin
                    phase <= bit_end ? 8'd0 : phase + 8'd1;
                    if (bit_end) begin
                        state    <= IDLE;
                        cs_n     <= 1'b1;
                        busy     <= 1'b0;
                        byte_cnt <= 16'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
